// File: rtl/acc_pkg.sv
// acc_pkg: shared types and constants for the signed accumulator and later ALU blocks.
//   WIDTH   : default operand/accumulator width.
//   state_t : accumulator FSM encoding.
//   SAT_MAX : most positive WIDTH-bit two's-complement value.
//   SAT_MIN : most negative WIDTH-bit two's-complement value.
package acc_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/bits4_accumulator_if.sv
// bits4_accumulator_if: control, operand stream and result stream of the accumulator.
//   start/len           : batch request, len sampled with start.
//   in_valid/in_data    : operand stream towards the accumulator; in_ready back.
//   out_valid/out_data  : batch total from the accumulator, with sticky out_ovf.
//   out_ready           : downstream acceptance of the result.
//   busy                : accumulator is not idle.
//   master drives requests/operands, slave is the accumulator.
interface bits4_accumulator_if
    import acc_pkg::*;
#(
    parameter int WIDTH = acc_pkg::WIDTH,
    parameter int LEN_W = 4
);

    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );

endinterface

// File: rtl/bits4_accumulator_signed_add4.sv
// signed_add4: combinational two's-complement ripple adder with signed overflow flag.
//   a, b : signed operands (WIDTH bits).
//   cin  : carry in.
//   sum  : a + b + cin truncated to WIDTH bits.
//   ovf  : signed overflow of the addition.
//   full_adder is the one-bit cell the ripple chain is built from.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module signed_add4 #(
    parameter int WIDTH = acc_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (sum[i]),
            .cout(c[i+1])
        );
    end

    // Carry into the sign bit differing from carry out of it is exactly
    // "same-sign operands produced an opposite-sign result".
    assign ovf = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/bits4_accumulator.sv
// bits4_accumulator: sums a batch of len signed operands with saturate-or-wrap overflow handling.
//   clk   : rising-edge clock.
//   rst_n : synchronous active-low reset.
//   bus   : slave side of bits4_accumulator_if (start/len, operand stream,
//           result stream with sticky overflow, busy).
//   SATURATE=1 clamps to the signed limits on overflow, 0 keeps the wrapped sum.
module bits4_accumulator
    import acc_pkg::*;
#(
    parameter int WIDTH    = acc_pkg::WIDTH,
    parameter int MAX_LEN  = 8,
    parameter int SATURATE = 1,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bits4_accumulator_if.slave   bus
);

    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [LEN_W-1:0] cnt, cnt_d;
    logic             ovf_sticky, ovf_sticky_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic [LEN_W-1:0] len_eff;
    logic             xfer;

    signed_add4 #(.WIDTH(WIDTH)) u_add (
        .a  (acc),
        .b  (bus.in_data),
        .cin(1'b0),
        .sum(sum),
        .ovf(add_ovf)
    );

    // A zero-length request still consumes one operand; oversize requests are clamped.
    assign len_eff = (bus.len == '0)                  ? LEN_W'(1)       :
                     (bus.len > LEN_W'(MAX_LEN))      ? LEN_W'(MAX_LEN) : bus.len;

    assign xfer = (state == ACCUM) && bus.in_valid;

    always_comb begin
        state_d      = state;
        acc_d        = acc;
        cnt_d        = cnt;
        ovf_sticky_d = ovf_sticky;
        out_data_d   = out_data_q;
        out_ovf_d    = out_ovf_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d      = ACCUM;
                    acc_d        = '0;
                    cnt_d        = len_eff;
                    ovf_sticky_d = 1'b0;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    // Saturation direction follows the old accumulator sign: an
                    // overflow needs both operands of the same sign.
                    acc_d        = (add_ovf && SATURATE != 0) ? (acc[WIDTH-1] ? S_MIN : S_MAX) : sum;
                    ovf_sticky_d = ovf_sticky | add_ovf;
                    cnt_d        = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_d    = DONE;
                        out_data_d = acc_d;
                        out_ovf_d  = ovf_sticky_d;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state      <= state_d;
            acc        <= acc_d;
            cnt        <= cnt_d;
            ovf_sticky <= ovf_sticky_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    // Result registers are loaded on entry to DONE and left untouched in IDLE,
    // so the last total stays visible after the handshake.
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_bits4_accumulator.sv
// tb_bits4_accumulator: scoreboard bench driving a saturating and a wrapping accumulator in lockstep.
module tb_bits4_accumulator;
    import acc_pkg::*;

    localparam int LEN_W = 4;

    typedef struct {
        int data;
        int ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   xfers   = 0;
    int   t0      = 0;
    int   x0      = 0;
    exp_t q_sat[$];
    exp_t q_wrap[$];
    int   ops[$];

    bits4_accumulator_if #(.WIDTH(4), .LEN_W(LEN_W)) bus ();
    bits4_accumulator_if #(.WIDTH(4), .LEN_W(LEN_W)) bus_w ();

    assign bus_w.start     = bus.start;
    assign bus_w.len       = bus.len;
    assign bus_w.in_valid  = bus.in_valid;
    assign bus_w.in_data   = bus.in_data;
    assign bus_w.out_ready = bus.out_ready;

    bits4_accumulator #(.WIDTH(4), .MAX_LEN(8), .SATURATE(1)) u_sat (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    bits4_accumulator #(.WIDTH(4), .MAX_LEN(8), .SATURATE(0)) u_wrap (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.in_valid && bus.in_ready) xfers <= xfers + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Every cycle a result is presented it must match the head of the queue,
    // so stalled outputs are checked for stability too; pop on handshake.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (q_sat.size() == 0) chk("sat_unexpected_output", 1, 0);
            else begin
                chk("sat_data", $signed(bus.out_data), q_sat[0].data);
                chk("sat_ovf", int'(bus.out_ovf), q_sat[0].ovf);
                if (bus.out_ready) void'(q_sat.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (bus_w.out_valid) begin
            if (q_wrap.size() == 0) chk("wrap_unexpected_output", 1, 0);
            else begin
                chk("wrap_data", $signed(bus_w.out_data), q_wrap[0].data);
                chk("wrap_ovf", int'(bus_w.out_ovf), q_wrap[0].ovf);
                if (bus_w.out_ready) void'(q_wrap.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input int l, input int ds, input int os, input int dw, input int ow);
        exp_t e;
        e.data = ds; e.ovf = os; q_sat.push_back(e);
        e.data = dw; e.ovf = ow; q_wrap.push_back(e);
        bus.start = 1'b1;
        bus.len   = LEN_W'(l);
        t0 = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed(input bit gap);
        for (int i = 0; i < ops.size(); i++) begin
            bit ok = 0;
            int g  = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(ops[i]);
            while (!ok && g < 20) begin
                @(negedge clk);
                ok = bus.in_ready;
                tick();
                g++;
            end
            if (!ok) chk("feed_accept_timeout", 0, 1);
            if (gap) begin
                bus.in_valid = 1'b0;
                tick();
            end
        end
        bus.in_valid = 1'b0;
        ops.delete();
    endtask

    task automatic wait_out();
        int g = 0;
        @(negedge clk);
        while (!bus.out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("out_valid_seen", int'(bus.out_valid), 1);
    endtask

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a batch discards it without output.
        bus.start = 1'b1; bus.len = 4'd3;
        tick();
        bus.start = 1'b0;
        ops = {2};
        feed(0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_state", int'(u_sat.state), int'(IDLE));
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_ovf", int'(bus.out_ovf), 0);
        chk("rst_busy", int'(bus.busy), 0);
        tick();

        // No overflow, back-to-back operands: result LEN+1 cycles after start.
        x0 = xfers;
        start_batch(3, 4, 0, 4, 0);
        ops = {2, 3, -1};
        feed(0);
        @(negedge clk);
        chk("latency_len3", cyc - t0, 4);
        chk("valid_after_len3", int'(bus.out_valid), 1);
        chk("xfers_len3", xfers - x0, 3);
        tick();

        // Positive overflow: 5+4.
        start_batch(2, 7, 1, -7, 1);
        ops = {5, 4};
        feed(0);
        wait_out();
        tick();

        // Negative overflow then recovery, sticky flag.
        start_batch(3, -5, 1, -8, 1);
        ops = {-6, -5};
        feed(0);
        @(negedge clk);
        chk("sat_acc_after_neg_ovf", $signed(u_sat.acc), -8);
        tick();
        ops = {3};
        feed(0);
        wait_out();
        tick();

        // Input gaps and a stalled output.
        bus.out_ready = 1'b0;
        x0 = xfers;
        start_batch(4, 2, 1, 3, 1);
        ops = {7, 1, -3, -2};
        feed(1);
        wait_out();
        repeat (5) @(negedge clk);
        chk("stall_busy", int'(bus.busy), 1);
        chk("stall_valid", int'(bus.out_valid), 1);
        chk("xfers_stall", xfers - x0, 4);
        tick();
        bus.out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_after_ready_valid", int'(bus.out_valid), 0);
        chk("idle_after_ready_busy", int'(bus.busy), 0);
        chk("idle_hold_data", $signed(bus.out_data), 2);
        chk("idle_hold_ovf", int'(bus.out_ovf), 1);
        tick();

        // len=0 consumes one operand; start during the DONE handshake is dropped.
        x0 = xfers;
        start_batch(0, 3, 0, 3, 0);
        chk("cnt_len0", int'(u_sat.cnt), 1);
        ops = {3};
        feed(0);
        bus.start = 1'b1; bus.len = 4'd2;
        @(negedge clk);
        chk("len0_valid", int'(bus.out_valid), 1);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_in_done_ignored", int'(bus.busy), 0);
        chk("xfers_len0", xfers - x0, 1);
        tick();

        // Oversize len clamps to MAX_LEN; extra valid data is not taken.
        x0 = xfers;
        start_batch(11, 7, 1, -8, 1);
        chk("cnt_clamp", int'(u_sat.cnt), 8);
        for (int i = 0; i < 8; i++) ops.push_back(1);
        feed(0);
        bus.in_valid = 1'b1; bus.in_data = 4'd1;
        @(negedge clk);
        chk("clamp_valid", int'(bus.out_valid), 1);
        chk("clamp_in_ready", int'(bus.in_ready), 0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("xfers_clamp", xfers - x0, 8);
        tick();

        // start while accumulating is ignored.
        x0 = xfers;
        start_batch(2, 5, 0, 5, 0);
        ops = {2};
        feed(0);
        bus.start = 1'b1; bus.len = 4'd5;
        tick();
        bus.start = 1'b0;
        chk("cnt_start_ignored", int'(u_sat.cnt), 1);
        chk("busy_start_ignored", int'(bus.busy), 1);
        ops = {3};
        feed(0);
        wait_out();
        tick();
        chk("xfers_start_ignored", xfers - x0, 2);

        repeat (3) tick();
        chk("sat_queue_empty", q_sat.size(), 0);
        chk("wrap_queue_empty", q_wrap.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
